turn_scheduler: RTL and testbench
=================================

# turn_scheduler

Match sequencer for the two-player artillery game. Owns whose turn it is, forwards the keyboard keycode only to the active player, runs the per-turn countdown, and waits for the active player's bomb to launch and detonate. After a settle window it checks both health values and either hands the turn over or declares the winner. Sits between the keyboard/keycode path and the two `player` instances; its outputs also drive the HUD (timer, turn marker, winner banner).

## Interface
- `FRAMES_PER_SEC`, default 60: frame ticks per countdown second.
- `TURN_SECS`, default 20: countdown reload value, range 1..255.
- `SETTLE_FRAMES`, default 90: frames to wait after detonation, so damage and health recovery can apply.
- `SHOT_TIMEOUT_FRAMES`, default 240: maximum frames in FLIGHT before the block forces SETTLE.
- `START_KEY`, default 8'h28: keycode that starts a match and that restarts after game over.
- `clk` in 1: system clock. The whole block is clocked on it.
- `reset` in 1: asynchronous, active-low reset.
- `frame_clk` in 1: vertical-sync frame strobe. Sampled, never used as a clock.
- `keycode` in 8: raw keycode from the keyboard.
- `launch0`, `launch1` in 1: bomb launch level from player 0 and player 1.
- `boomed0`, `boomed1` in 1: bomb detonation level from player 0 and player 1.
- `hp0`, `hp1` in 10: health of player 0 and player 1.
- `keycode0`, `keycode1` out 8: gated keycode delivered to each player.
- `turn` out 1: ID of the active player.
- `state` out 3: state encoding, for the HUD and debug.
- `time_left` out 8: seconds remaining in the AIM state.
- `winner` out 2: 00 none, 01 player 0 won, 10 player 1 won, 11 draw.
- `game_over` out 1: high while in OVER.

## Operation
- **Input synchronisers.** `frame_clk`, `launch*` and `boomed*` each pass through a 2-flop synchroniser.
  - `frame_tick` is a 1-cycle pulse on the rising edge of the synchronised `frame_clk`.
  - `launch_rise` and `boom_rise` are rising edges of the synchronised launch and boomed signals, selected by `turn`.
  - Edges from the non-active player are ignored.
- **Start-key edge.** `start_rise` is high when `keycode == START_KEY` this cycle and was not equal to it last cycle.
- **Death test.** A player is dead when `hp == 0` or `hp[9] == 1`.
- **States** (encoding): IDLE=0, AIM=1, FLIGHT=2, SETTLE=3, SWITCH=4, OVER=5.
  - IDLE: on `start_rise`, load `turn`=0, `time_left`=TURN_SECS, clear `fcnt` and `winner`, and go to AIM.
  - AIM: `fcnt` increments on every `frame_tick`. When `fcnt` reaches FRAMES_PER_SEC-1, `fcnt` returns to 0 and `time_left` decrements.
    - If `launch_rise` occurs, go to FLIGHT and clear `fcnt`.
    - Otherwise, if the decrement makes `time_left` 0, go to SWITCH (the turn is forfeited).
    - If both happen in the same cycle, launch wins.
  - FLIGHT: `fcnt` counts frame ticks. Go to SETTLE and clear `fcnt` on `boom_rise`, or when `fcnt` reaches SHOT_TIMEOUT_FRAMES-1 on a tick. If both occur together, the result is the same: SETTLE.
  - SETTLE: `fcnt` counts frame ticks. When it reaches SETTLE_FRAMES-1 on a tick, evaluate health:
    - both players dead: `winner`=11, go to OVER;
    - player 0 dead: `winner`=10, go to OVER;
    - player 1 dead: `winner`=01, go to OVER;
    - otherwise go to SWITCH.
  - SWITCH: lasts exactly 1 cycle. Toggle `turn`, set `time_left`=TURN_SECS, clear `fcnt`, go to AIM.
  - OVER: holds `winner`. On `start_rise`, go to IDLE and clear `winner`.
- **Keycode gating** (combinational from registered state):
  - `keycode0` = `keycode` when `state==AIM` and `turn==0`, else 0.
  - `keycode1` = `keycode` when `state==AIM` and `turn==1`, else 0.
- **Counter widths.** `fcnt` is 9 bits and is only compared for equality. `time_left` never underflows; it is only reloaded in IDLE and SWITCH.

## Timing
- **Reset values.** While `reset` is low: `state`=IDLE, `turn`=0, `time_left`=0, `winner`=00, `game_over`=0, `keycode0`=`keycode1`=0, `fcnt`=0, synchroniser flops 0.
- **Reset mid-match.** Reset immediately returns the block to IDLE; no winner is recorded.
- **frame_clk latency.** From a `frame_clk` rise, `frame_tick` pulses exactly 3 `clk` cycles later, with 1 pulse per frame. `launch` and `boomed` edges are seen 3 cycles after they rise.
- **State changes.** Every state change is registered, 1 cycle after its trigger. Gated keycodes follow `state` with 0 added latency.
- **Turn changes.** `turn` changes only on the SWITCH→AIM edge. `game_over` = (`state`==OVER).
- **Stale edges.** A `launch` level still high from the previous turn produces no edge, so no false launch.

## Test plan
Unless stated otherwise, the bench uses FRAMES_PER_SEC=4, TURN_SECS=3, SETTLE_FRAMES=5, SHOT_TIMEOUT_FRAMES=10.
- **Reset and start.** Apply reset low, then release → all outputs at reset values. Drive `keycode`=8'h28 → AIM, `turn`=0, `time_left`=3. Drive `keycode`=8'h04 → `keycode0`=8'h04, `keycode1`=0.
- **Forfeit.** In AIM with no launch, send 12 frame ticks → `time_left` steps 2,1,0, then SWITCH for 1 cycle, then AIM with `turn`=1 and `time_left`=3.
- **Normal shot.** Pulse `launch0`, then `boomed0` 6 frames later, with `hp` values nonzero → FLIGHT, SETTLE, 5 ticks, SWITCH, `turn`=1. Keycodes read 0 throughout FLIGHT and SETTLE.
- **Kill and restart.** Use `hp1`=0 at the end of SETTLE → OVER, `winner`=01, `game_over`=1. Repeat with `hp0`=10'h3F6 and `hp1`=0 → `winner`=11. Hold START_KEY without release → stays OVER until a fresh press → IDLE.
- **Wrong player and timeout.** Pulse `launch1` or `boomed1` while `turn`=0 → ignored. In FLIGHT with no boomed, send 10 ticks → SETTLE.
- **Simultaneous events.** Drive `launch_rise` in the same cycle that `time_left` decrements to 0 → FLIGHT, not SWITCH. Assert `reset` in FLIGHT → IDLE immediately.

Source files
------------

// File: rtl/turn_scheduler.sv
// turn_scheduler: match sequencer for the two-player artillery game.
// Tracks whose turn it is, gates the keycode to the active player, runs the
// per-turn countdown, follows the shot through flight and settle, then either
// passes the turn or declares the winner.
module turn_scheduler #(
  parameter int unsigned FRAMES_PER_SEC      = 60,
  parameter int unsigned TURN_SECS           = 20,
  parameter int unsigned SETTLE_FRAMES       = 90,
  parameter int unsigned SHOT_TIMEOUT_FRAMES = 240,
  parameter logic [7:0]  START_KEY           = 8'h28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       launch0,
  input  logic       launch1,
  input  logic       boomed0,
  input  logic       boomed1,
  input  logic [9:0] hp0,
  input  logic [9:0] hp1,
  output logic [7:0] keycode0,
  output logic [7:0] keycode1,
  output logic       turn,
  output logic [2:0] state,
  output logic [7:0] time_left,
  output logic [1:0] winner,
  output logic       game_over
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AIM    = 3'd1,
    FLIGHT = 3'd2,
    SETTLE = 3'd3,
    SWITCH = 3'd4,
    OVER   = 3'd5
  } state_t;

  localparam logic [8:0] SEC_LAST    = 9'(FRAMES_PER_SEC - 1);
  localparam logic [8:0] SHOT_LAST   = 9'(SHOT_TIMEOUT_FRAMES - 1);
  localparam logic [8:0] SETTLE_LAST = 9'(SETTLE_FRAMES - 1);
  localparam logic [7:0] TURN_RELOAD = 8'(TURN_SECS);

  state_t     state_q;
  logic       turn_q;
  logic [7:0] time_left_q;
  logic [1:0] winner_q;
  logic [8:0] fcnt;

  // frame_sync[1:0] is the 2-flop synchroniser, frame_sync[2] the edge history
  logic [2:0] frame_sync;
  // index 0 = player 0, index 1 = player 1
  logic [1:0] launch_meta, launch_sync, launch_prev;
  logic [1:0] boom_meta, boom_sync, boom_prev;
  logic       key_was_start;

  logic       frame_tick;
  logic [1:0] launch_edge, boom_edge;
  logic       launch_rise, boom_rise;
  logic       start_rise;
  logic       dead0, dead1;

  function automatic logic is_dead(input logic [9:0] hp);
    return (hp == '0) || hp[9];
  endfunction

  assign frame_tick  = frame_sync[1] & ~frame_sync[2];
  assign launch_edge = launch_sync & ~launch_prev;
  assign boom_edge   = boom_sync & ~boom_prev;
  // Edges from the idle player are dropped here; the history flops keep
  // running for both players, so a level left high never yields a late edge.
  assign launch_rise = launch_edge[turn_q];
  assign boom_rise   = boom_edge[turn_q];
  assign start_rise  = (keycode == START_KEY) && !key_was_start;
  assign dead0       = is_dead(hp0);
  assign dead1       = is_dead(hp1);

  // Synchronise asynchronous inputs and keep one cycle of edge history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_sync    <= '0;
      launch_meta   <= '0;
      launch_sync   <= '0;
      launch_prev   <= '0;
      boom_meta     <= '0;
      boom_sync     <= '0;
      boom_prev     <= '0;
      key_was_start <= 1'b0;
    end else begin
      frame_sync    <= {frame_sync[1:0], frame_clk};
      launch_meta   <= {launch1, launch0};
      launch_sync   <= launch_meta;
      launch_prev   <= launch_sync;
      boom_meta     <= {boomed1, boomed0};
      boom_sync     <= boom_meta;
      boom_prev     <= boom_sync;
      key_was_start <= (keycode == START_KEY);
    end
  end

  // Match sequencer: turn ownership, countdown, shot tracking and outcome
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      turn_q      <= 1'b0;
      time_left_q <= '0;
      winner_q    <= '0;
      fcnt        <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_rise) begin
            turn_q      <= 1'b0;
            time_left_q <= TURN_RELOAD;
            fcnt        <= '0;
            winner_q    <= '0;
            state_q     <= AIM;
          end
        end
        AIM: begin
          if (frame_tick) begin
            if (fcnt == SEC_LAST) begin
              fcnt <= '0;
              if (time_left_q != '0) time_left_q <= time_left_q - 8'd1;
            end else begin
              fcnt <= fcnt + 9'd1;
            end
          end
          // A launch in the same cycle as the final decrement takes priority
          if (launch_rise) begin
            fcnt    <= '0;
            state_q <= FLIGHT;
          end else if (frame_tick && (fcnt == SEC_LAST) && (time_left_q == 8'd1)) begin
            state_q <= SWITCH;
          end
        end
        FLIGHT: begin
          if (boom_rise || (frame_tick && (fcnt == SHOT_LAST))) begin
            fcnt    <= '0;
            state_q <= SETTLE;
          end else if (frame_tick) begin
            fcnt <= fcnt + 9'd1;
          end
        end
        SETTLE: begin
          if (frame_tick) begin
            if (fcnt == SETTLE_LAST) begin
              fcnt <= '0;
              if (dead0 && dead1) begin
                winner_q <= 2'b11;
                state_q  <= OVER;
              end else if (dead0) begin
                winner_q <= 2'b10;
                state_q  <= OVER;
              end else if (dead1) begin
                winner_q <= 2'b01;
                state_q  <= OVER;
              end else begin
                state_q <= SWITCH;
              end
            end else begin
              fcnt <= fcnt + 9'd1;
            end
          end
        end
        SWITCH: begin
          turn_q      <= ~turn_q;
          time_left_q <= TURN_RELOAD;
          fcnt        <= '0;
          state_q     <= AIM;
        end
        OVER: begin
          if (start_rise) begin
            winner_q <= '0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Deliver the keycode only to the player currently aiming
  always_comb begin
    keycode0 = '0;
    keycode1 = '0;
    if (state_q == AIM) begin
      if (!turn_q) keycode0 = keycode;
      else         keycode1 = keycode;
    end
  end

  assign state     = state_q;
  assign turn      = turn_q;
  assign time_left = time_left_q;
  assign winner    = winner_q;
  assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_turn_scheduler.sv
// tb_turn_scheduler: directed plus randomized checks of turn_scheduler against
// an event-level game model (frames counted per phase, outcome from health).
module tb_turn_scheduler;

  localparam int         FPS = 4;
  localparam int         TS  = 3;
  localparam int         SF  = 5;
  localparam int         ST  = 10;
  localparam logic [7:0] SK  = 8'h28;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       launch0, launch1, boomed0, boomed1;
  logic [9:0] hp0, hp1;
  logic [7:0] keycode0, keycode1;
  logic       turn;
  logic [2:0] state;
  logic [7:0] time_left;
  logic [1:0] winner;
  logic       game_over;

  turn_scheduler #(
    .FRAMES_PER_SEC     (FPS),
    .TURN_SECS          (TS),
    .SETTLE_FRAMES      (SF),
    .SHOT_TIMEOUT_FRAMES(ST),
    .START_KEY          (SK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .frame_clk(frame_clk),
    .keycode  (keycode),
    .launch0  (launch0),
    .launch1  (launch1),
    .boomed0  (boomed0),
    .boomed1  (boomed1),
    .hp0      (hp0),
    .hp1      (hp1),
    .keycode0 (keycode0),
    .keycode1 (keycode1),
    .turn     (turn),
    .state    (state),
    .time_left(time_left),
    .winner   (winner),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Game model: phase name, owner, and number of frames seen in the phase
  int m_state;   // 0 idle,1 aim,2 flight,3 settle,5 over (switch is transient)
  int m_turn, m_time, m_winner;
  int m_aim_frames, m_flight_frames, m_settle_frames;
  int m_switches;
  bit m_key_was_start;

  // Cycles spent in the SWITCH state, sampled mid-cycle
  int sw_cycles = 0;
  always @(negedge clk) if (reset === 1'b1 && state === 3'd4) sw_cycles++;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task check_all(input string tag);
    logic [7:0] e_k0, e_k1;
    e_k0 = (m_state == 1 && m_turn == 0) ? keycode : 8'h00;
    e_k1 = (m_state == 1 && m_turn == 1) ? keycode : 8'h00;
    chk({tag, "/state"},     32'(state),     32'(m_state));
    chk({tag, "/turn"},      32'(turn),      32'(m_turn));
    chk({tag, "/time_left"}, 32'(time_left), 32'(m_time));
    chk({tag, "/winner"},    32'(winner),    32'(m_winner));
    chk({tag, "/game_over"}, 32'(game_over), 32'(m_state == 5));
    chk({tag, "/keycode0"},  32'(keycode0),  32'(e_k0));
    chk({tag, "/keycode1"},  32'(keycode1),  32'(e_k1));
    chk({tag, "/switch_cycles"}, 32'(sw_cycles), 32'(m_switches));
  endtask

  function automatic bit dead(input logic [9:0] hp);
    return (hp == 10'd0) || (hp >= 10'd512);
  endfunction

  function automatic logic [9:0] rand_hp();
    if ($urandom_range(0, 5) == 0)
      return ($urandom_range(0, 1) == 1) ? 10'd0 : (10'h200 | 10'($urandom_range(0, 511)));
    return 10'($urandom_range(1, 511));
  endfunction

  task m_reset();
    m_state = 0; m_turn = 0; m_time = 0; m_winner = 0;
    m_aim_frames = 0; m_flight_frames = 0; m_settle_frames = 0;
    m_key_was_start = 1'b0;
  endtask

  task m_begin_turn(input int t);
    m_state = 1; m_turn = t; m_time = TS; m_aim_frames = 0;
  endtask

  task m_frame();
    case (m_state)
      1: begin
        m_aim_frames++;
        m_time = TS - m_aim_frames / FPS;
        if (m_aim_frames == TS * FPS) begin
          m_switches++;
          m_begin_turn(1 - m_turn);
        end
      end
      2: begin
        m_flight_frames++;
        if (m_flight_frames == ST) begin m_state = 3; m_settle_frames = 0; end
      end
      3: begin
        m_settle_frames++;
        if (m_settle_frames == SF) begin
          if (dead(hp0) && dead(hp1)) begin m_winner = 3; m_state = 5; end
          else if (dead(hp0))         begin m_winner = 2; m_state = 5; end
          else if (dead(hp1))         begin m_winner = 1; m_state = 5; end
          else begin m_switches++; m_begin_turn(1 - m_turn); end
        end
      end
      default: ;
    endcase
  endtask

  task do_frame(input string tag);
    frame_clk = 1'b1;
    repeat (4) @(posedge clk);
    #1 frame_clk = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    m_frame();
    check_all(tag);
  endtask

  task pulse(input int which, input int p, input logic fr);
    frame_clk = fr;
    if (which == 0) begin if (p == 0) launch0 = 1'b1; else launch1 = 1'b1; end
    else            begin if (p == 0) boomed0 = 1'b1; else boomed1 = 1'b1; end
    repeat (4) @(posedge clk);
    #1;
    frame_clk = 1'b0; launch0 = 1'b0; launch1 = 1'b0; boomed0 = 1'b0; boomed1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task do_launch(input int p, input string tag);
    pulse(0, p, 1'b0);
    if (m_state == 1 && p == m_turn) begin m_state = 2; m_flight_frames = 0; end
    check_all(tag);
  endtask

  task do_boom(input int p, input string tag);
    pulse(1, p, 1'b0);
    if (m_state == 2 && p == m_turn) begin m_state = 3; m_settle_frames = 0; end
    check_all(tag);
  endtask

  // Frame strobe and launch rising together: launch beats the countdown
  task do_frame_launch(input int p, input string tag);
    pulse(0, p, 1'b1);
    if (m_state == 1 && p == m_turn) begin
      m_aim_frames++;
      m_time = TS - m_aim_frames / FPS;
      m_state = 2; m_flight_frames = 0;
    end else begin
      m_frame();
    end
    check_all(tag);
  endtask

  task do_key(input logic [7:0] k, input string tag);
    @(posedge clk);
    #1 keycode = k;
    if (k == SK && !m_key_was_start) begin
      if (m_state == 0) begin m_begin_turn(0); m_winner = 0; end
      else if (m_state == 5) begin m_state = 0; m_winner = 0; end
    end
    m_key_was_start = (k == SK);
    repeat (2) @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0; frame_clk = 1'b0; keycode = 8'h00;
    launch0 = 1'b0; launch1 = 1'b0; boomed0 = 1'b0; boomed1 = 1'b0;
    hp0 = 10'd100; hp1 = 10'd100;
    m_reset(); m_switches = 0;
    #23;
    check_all("reset_hold");
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all("reset_release");

    // Start and keycode routing
    do_key(SK, "start");
    do_key(8'h04, "key_route");

    // Forfeit: twelve frames drain the countdown, turn passes to player 1
    for (int i = 0; i < 12; i++) do_frame("forfeit");

    // Normal shot by player 1, with wrong-player events ignored
    do_launch(0, "wrong_launch");
    do_frame("aim_frame");
    do_launch(1, "launch1");
    do_boom(0, "wrong_boom");
    for (int i = 0; i < 6; i++) do_frame("flight");
    do_boom(1, "boom1");
    hp0 = rand_hp(); hp1 = rand_hp();
    if (dead(hp0)) hp0 = 10'd300;
    if (dead(hp1)) hp1 = 10'd301;
    for (int i = 0; i < 5; i++) do_frame("settle");

    // Shot timeout, then player 1 killed
    do_launch(1, "wrong_launch_t0");
    do_boom(1, "wrong_boom_t0");
    do_launch(0, "launch0");
    for (int i = 0; i < 10; i++) do_frame("timeout");
    hp1 = 10'd0;
    for (int i = 0; i < 5; i++) do_frame("kill_p1");

    // Restart, then both dead (3F6 has bit 9 set)
    do_key(8'h00, "over_release");
    do_key(SK, "over_to_idle");
    do_key(8'h00, "idle_release");
    do_key(SK, "restart");
    hp0 = 10'd200; hp1 = 10'd200;
    do_launch(0, "launch_draw");
    do_boom(0, "boom_draw");
    hp0 = 10'h3F6; hp1 = 10'd0;
    for (int i = 0; i < 5; i++) do_frame("draw");
    repeat (20) @(posedge clk);
    #1 check_all("over_key_held");
    do_key(8'h00, "over_release2");
    do_key(SK, "over_to_idle2");
    do_key(8'h00, "idle_release2");
    do_key(SK, "restart2");

    // Launch in the same cycle the countdown reaches zero
    hp0 = 10'd50; hp1 = 10'd60;
    for (int i = 0; i < 11; i++) do_frame("count_down");
    do_frame_launch(0, "launch_vs_zero");

    // Asynchronous reset while in flight
    do_key(8'h00, "pre_reset_key");
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    m_reset();
    check_all("reset_in_flight");
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all("reset_release2");

    // Randomized play
    for (int n = 0; n < 200; n++) begin
      int r;
      int p;
      logic [7:0] k;
      if (m_state == 0 || m_state == 5) begin
        do_key(8'h00, "rnd_release");
        do_key(SK, "rnd_start");
      end
      r = $urandom_range(0, 9);
      p = $urandom_range(0, 1);
      case (r)
        0, 1, 2, 3: do_frame("rnd_frame");
        4: do_launch(($urandom_range(0, 3) == 0) ? p : m_turn, "rnd_launch");
        5: do_boom(($urandom_range(0, 3) == 0) ? p : m_turn, "rnd_boom");
        6: do_frame_launch(p, "rnd_frame_launch");
        7: begin
          k = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 2) == 0) k = SK;
          do_key(k, "rnd_key");
        end
        default: begin
          hp0 = rand_hp(); hp1 = rand_hp();
          do_frame("rnd_hp_frame");
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
